// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

    localparam int DIV_N = 11;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } div_state_e;

    // One extra bit so the most-negative value has a representable magnitude.
    function automatic logic [2*DIV_N:0] dvd_mag(input logic [2*DIV_N-1:0] v);
        logic [2*DIV_N:0] x;
        x = {v[2*DIV_N-1], v};
        return x[2*DIV_N] ? -x : x;
    endfunction

    function automatic logic [DIV_N:0] dvs_mag(input logic [DIV_N-1:0] v);
        logic [DIV_N:0] x;
        x = {v[DIV_N-1], v};
        return x[DIV_N] ? -x : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
module div_step
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N-1:0] rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] dvs_i,
    output logic [N-1:0] rem_o,
    output logic         q_o
);

    logic [N:0] trial;
    logic [N:0] diff;

    always_comb begin
        trial = {rem_i, bit_i};
        diff  = trial - {1'b0, dvs_i};
        q_o   = ~diff[N];
        rem_o = q_o ? diff[N-1:0] : trial[N-1:0];
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed restoring divider, one quotient bit per cycle.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(N);
    localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};

    div_state_e     state_q, state_d;
    logic [2*N-1:0] dvd_q, dvd_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic           sd_q, sd_d;
    logic           sv_q, sv_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [N-1:0]   sh_q, sh_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   remd_q, remd_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;

    logic [2*N:0]   dvd_m;
    logic [N:0]     dvs_m;
    logic [N-1:0]   step_rem;
    logic           step_q;
    logic           neg;

    assign dvd_m = dvd_mag(dvd_q);
    assign dvs_m = dvs_mag(dvs_q);

    div_step #(.N(N)) u_step (
        .rem_i (rem_q),
        .bit_i (sh_q[N-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        sd_d    = sd_q;
        sv_d    = sv_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remd_d  = remd_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        neg     = sd_q ^ sv_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    sd_d    = dividend[2*N-1];
                    sv_d    = divisor[N-1];
                    quot_d  = '0;
                    remd_d  = '0;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (dvs_q == '0) begin
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else if (dvd_m[2*N:N] >= dvs_m) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    rem_d   = dvd_m[2*N-1:N];
                    sh_d    = dvd_m[N-1:0];
                    dvs_d   = dvs_m[N-1:0];
                    cnt_d   = CW'(N-1);
                    state_d = CALC;
                end
            end
            CALC: begin
                // Dividend bits leave the top of sh while quotient bits enter below.
                rem_d = step_rem;
                sh_d  = {sh_q[N-2:0], step_q};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (neg ? (sh_q > HALF) : (sh_q >= HALF)) begin
                    ovf_d = 1'b1;
                end else begin
                    quot_d = neg ? -sh_q : sh_q;
                    remd_d = sd_q ? -rem_q : rem_q;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            sd_q    <= 1'b0;
            sv_q    <= 1'b0;
            rem_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remd_q  <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            sd_q    <= sd_d;
            sv_q    <= sv_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = remd_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Randomized and directed checks of seq_signed_divider against an arithmetic model.
module tb_seq_signed_divider;

    localparam int N = 11;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [2*N-1:0]        dividend;
    logic [N-1:0]          divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [N-1:0]   quotient;
    logic signed [N-1:0]   remainder;
    logic                  div_by_zero;
    logic                  overflow;

    int n_cmp = 0;
    int n_err = 0;

    seq_signed_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain signed arithmetic, truncating division.
    task automatic model(input longint a, input longint b,
                         output longint q, output longint r,
                         output longint dbz, output longint ovf,
                         output longint lat);
        q = 0; r = 0; dbz = 0; ovf = 0; lat = N + 2;
        if (b == 0) begin
            dbz = 1;
            lat = 1;
        end else begin
            q = a / b;
            r = a % b;
            if (q >= (1 <<< N) || q <= -(1 <<< N)) begin
                ovf = 1; lat = 1; q = 0; r = 0;
            end else if (q > (1 <<< (N-1)) - 1 || q < -(1 <<< (N-1))) begin
                ovf = 1; q = 0; r = 0;
            end
        end
    endtask

    task automatic run(input longint a, input longint b, input int hold);
        longint eq, er, edbz, eovf, elat;
        int     cyc;
        bit     seen;
        model(a, b, eq, er, edbz, eovf, elat);
        @(negedge clk);
        dividend = a[2*N-1:0];
        divisor  = b[N-1:0];
        in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 22'($urandom);
        divisor  = 11'($urandom);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = out_valid;
        end
        chk("latency", seen ? cyc : -1, elat);
        if (!seen) return;
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, edbz);
        chk("overflow", overflow, eovf);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_quotient", quotient, eq);
            chk("hold_remainder", remainder, er);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_cleared", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    initial begin
        logic signed [2*N-1:0] ra;
        logic signed [N-1:0]   rb;
        longint a, b;
        int     seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_ovf", overflow, 0);

        run(1000, 7, 0);
        run(-1000, 7, 0);
        run(1000, -7, 0);
        run(-1000, -7, 0);
        run(1024, 1, 0);
        run(-1024, 1, 0);
        run(1 <<< 20, 1, 0);
        run(555, 0, 0);
        run(1000, 7, 5);
        run(-(1 <<< 21), -1024, 0);
        run(-(1 <<< 21), 1, 0);
        run(-1048576, -1024, 0);
        run(1048575, -1024, 0);
        run((1 <<< 21) - 1, 1023, 2);
        run(-1048576, 1024 - 2048, 0);
        run(-7, 1000, 0);

        // Abort a division with reset during the CALC phase.
        @(negedge clk);
        dividend = 22'd1000;
        divisor  = 11'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        chk("abort_no_valid", seen, 0);
        chk("abort_in_ready", in_ready, 1);
        run(1000, 7, 0);

        for (int k = 0; k < 200; k++) begin
            ra = 22'($urandom);
            ra = ra >>> $urandom_range(0, 2*N-1);
            rb = 11'($urandom);
            if ($urandom_range(0, 15) == 0) rb = '0;
            if ($urandom_range(0, 15) == 0) rb = 11'h400;
            if ($urandom_range(0, 3) == 0) rb = rb >>> $urandom_range(0, N-1);
            a = longint'(ra);
            b = longint'(rb);
            run(a, b, $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 3)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Sequential signed restoring divider: the inverse of the radix-4 Dadda multiplier datapath.
- Takes a 2N-bit signed dividend (multiplier product width) and an N-bit signed divisor. Returns an N-bit quotient (truncated toward zero) and an N-bit remainder (sign of dividend).
- Produces one quotient bit per cycle, with valid/ready handshakes on both sides.
- Sits beside the multiplier for round-trip checks and for division in the arithmetic unit.

Parameters:
- N, 11, operand width; dividend is 2N bits, quotient and remainder are N bits each.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  divider can accept operands
- dividend  in  2N  signed dividend
- divisor  in  N  signed divisor
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- quotient  out  N  signed quotient
- remainder  out  N  signed remainder
- div_by_zero  out  1  divisor was 0
- overflow  out  1  quotient not representable in N-bit signed

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst_n). While rst_n=0 at a rising edge:
  - state goes to IDLE
  - out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0
  - in_ready=1 after the edge
- Reset mid-operation aborts silently; no result is emitted.
- in_ready is 1 only in IDLE. Operands are accepted on an edge with in_valid && in_ready (edge T).
- States and transitions:
  - IDLE: on accept, register operands and signs, go to PREP.
  - PREP: form |dividend| (2N bits) and |divisor| (N bits).
    - divisor==0 -> DONE with div_by_zero=1.
    - else if the upper N bits of |dividend| >= |divisor| -> DONE with overflow=1.
    - else load partial remainder = upper N bits, shift register = lower N bits, counter = N-1, go to CALC.
  - CALC: one restoring step per cycle.
    - Trial = {partial remainder, next dividend bit} minus |divisor|, evaluated at N+1 bits.
    - If trial >= 0: take the difference and shift in quotient bit 1; else shift in 0.
    - After N steps go to FIX.
  - FIX: apply signs.
    - quotient negated if the operand signs differ; remainder negated if the dividend is negative.
    - Range check: positive quotient magnitude > 2^(N-1)-1, or negative magnitude > 2^(N-1), sets overflow=1.
    - Go to DONE.
  - DONE: out_valid=1. Outputs hold stable while out_ready=0. On out_valid && out_ready go to IDLE and clear out_valid on the same edge.
- Latency:
  - Normal path: out_valid=1 after edge T+N+2 (T+13 for N=11).
  - Error path: out_valid=1 after edge T+1.
- On any error (div_by_zero or overflow): quotient=0 and remainder=0. The two flags are mutually exclusive.
- Boundary cases:
  - Most-negative dividend: magnitude formed in 2N+1 bits internally; no wrap.
  - Most-negative divisor: magnitude 2^(N-1) handled in N+1-bit compare.
  - Quotient -2^(N-1) is legal, not overflow.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.

Decomposition:
- Package div_pkg:
  - state enum (IDLE, PREP, CALC, FIX, DONE)
  - constant DIV_N=11
  - helper function for two's-complement magnitude
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: partial remainder, incoming bit, |divisor|.
  - Outputs: next remainder, quotient bit.
  - Instantiated once in CALC.

Test Plan:
- 1000 / 7 -> quotient 142, remainder 6, no flags, out_valid exactly 13 cycles after accept.
- -1000 / 7 -> quotient -142, remainder -6. 1000 / -7 -> quotient -142, remainder 6. -1000 / -7 -> quotient 142, remainder -6.
- 1024 / 1 -> overflow=1, quotient 0, remainder 0 (caught in FIX). -1024 / 1 -> quotient -1024, no overflow. 2^20 / 1 -> overflow=1 after edge T+1 (PREP precheck).
- 555 / 0 -> div_by_zero=1, overflow=0, out_valid after edge T+1.
- Hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout. After out_ready=1 -> IDLE, in_ready=1 next cycle; back-to-back accept works.
- Drop rst_n for one edge at CALC step 5 -> out_valid never asserts, in_ready=1 afterwards, and a fresh 1000/7 returns 142 r 6.
